pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the RV32I core. It holds the architectural PC and computes the next PC for sequential, branch, jal and jalr flow. It checks target alignment, accepts trap redirects, and counts retired instructions. It sits between the control-word decoder/ALU and instruction fetch, and replaces the fixed-width, always-advancing PC adder.

## Interface
Parameters:
- XLEN, 32, datapath/PC width in bits
- RESET_VECTOR, 32'h0000_0000, PC value on reset; must be aligned to the configured instruction alignment
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- cword  in  23  control word; bits [3:0] = instType (0 load, 1 imm, 2 store, 3 reg, 4 lui, 5 auipc, 6 branch, 7 jalr, 8 jal)
- imm  in  XLEN  sign-extended immediate of the current instruction
- r  in  XLEN  rs1 value, used by jalr
- br_taken  in  1  branch condition result from the ALU; valid when instType=6
- instr_c  in  1  current instruction is 16-bit; ignored unless C_EXT_EN is defined
- adv  in  1  current instruction retires this cycle; the PC advances
- trap_req  in  1  redirect to trap_vec
- trap_vec  in  XLEN  trap handler address
- pc  out  XLEN  registered current PC
- pc_next  out  XLEN  combinational target the PC would take on adv
- link  out  XLEN  combinational pc + ilen, the return address for jal/jalr
- pc_valid  out  1  registered; pc may be fetched
- misalign  out  1  registered; the sequencer is in FAULT
- instret  out  CNT_W  registered retired-instruction count

## Operation
- **ilen:** 2 when C_EXT_EN is defined and instr_c=1; otherwise 4.
- **Target selection (pc_next):**
  - jal (8): pc + imm
  - jalr (7): (r + imm) with bit 0 cleared
  - branch (6): br_taken ? pc + imm : pc + ilen
  - all other types, including auipc: pc + ilen
- **Arithmetic:** all sums are modulo 2^XLEN, and carry-out is discarded. Wrap from all-ones to 0 is legal and is not a fault.
- **Alignment:** a target is misaligned if bit 1 is set (IALIGN=32). Under C_EXT_EN, no target can be misaligned because jalr already clears bit 0.
- **State machine:** BOOT, RUN, FAULT.
  - **BOOT:** entered on reset. pc=RESET_VECTOR, pc_valid=0. Moves unconditionally to RUN on the first clock edge. adv and trap_req are ignored in BOOT.
  - **RUN:** pc_valid=1.
    - trap_req=1: pc <= trap_vec with bit 0 cleared (bits 1:0 cleared without C_EXT_EN); stay in RUN.
    - Otherwise, adv=1 and pc_next aligned: pc <= pc_next, and instret increments.
    - Otherwise, adv=1 and pc_next misaligned: pc holds, instret does not increment, go to FAULT with misalign=1.
    - adv=0: everything holds.
  - **FAULT:** pc_valid=0, misalign=1, pc frozen at the faulting instruction's address, and adv is ignored. trap_req: pc <= trap_vec (aligned as above), misalign=0, go to RUN.
- **Simultaneous events:** trap_req and adv in the same cycle: the trap wins, and instret does not increment.
- **instret:** wraps modulo 2^CNT_W.

## Timing
- **Reset values:** pc=RESET_VECTOR, pc_valid=0, misalign=0, instret=0, state=BOOT.
- **Reset timing:** reset takes effect immediately on rst_n falling, including mid-instruction. First pc_valid=1 is one clock edge after rst_n rises.
- **Latency:** pc, pc_valid, misalign and instret update one edge after the qualifying adv/trap_req cycle. pc_next and link are combinational from pc, cword, imm, r, br_taken and instr_c, with zero latency.
- **Hold:** adv=0 in RUN holds all registered outputs indefinitely; this is the stall mechanism.

## Configuration
- **C_EXT_EN defined:**
  - instr_c selects ilen=2.
  - Alignment is 2-byte, so FAULT is unreachable from adv.
  - RESET_VECTOR needs only 2-byte alignment.
- **C_EXT_EN undefined:**
  - instr_c is ignored and ilen is fixed at 4.
  - Targets with bit 1 set fault.

## Test plan
- Reset mid-run at pc=0x40 -> pc=0x0 and pc_valid=0 immediately. After release: one edge later pc_valid=1; three adv cycles with instType=3 -> pc=0xC, instret=3.
- pc=0x100, branch, imm=0xFFFF_FFF0: with br_taken=1, adv -> pc=0xF0. Same setup with br_taken=0 -> pc=0x104; link=0x104 before the edge in both cases.
- jalr with r=0x2001, imm=0x4 -> pc=0x2004, bit 0 cleared. jal at pc=0xFFFF_FFFC with imm=0x8 -> pc=0x4 (wrap).
- Without C_EXT_EN, jal at pc=0x10 with imm=0x2 -> misalign=1, pc_valid=0, pc=0x10, instret unchanged; adv ignored. Then trap_req with trap_vec=0x803 -> pc=0x800, misalign=0, RUN.
- trap_req and adv in the same cycle with pc_next=0x24, trap_vec=0x200 -> pc=0x200, instret unchanged.
- With C_EXT_EN, pc=0x10, instr_c=1, instType=1, adv -> pc=0x12. Then jal imm=0x2 -> pc=0x14, no fault.

Source files
------------

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module   : pc_sequencer_if
// Brief    : Control/datapath bundle between decoder/ALU and the PC sequencer.
// Revision : 1.0
// =============================================================================
interface pc_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [22:0]      cword;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  r;
    logic             br_taken;
    logic             instr_c;
    logic             adv;
    logic             trap_req;
    logic [XLEN-1:0]  trap_vec;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  link;
    logic             pc_valid;
    logic             misalign;
    logic [CNT_W-1:0] instret;

    modport master (
        output cword, imm, r, br_taken, instr_c, adv, trap_req, trap_vec,
        input  pc, pc_next, link, pc_valid, misalign, instret
    );

    modport slave (
        input  cword, imm, r, br_taken, instr_c, adv, trap_req, trap_vec,
        output pc, pc_next, link, pc_valid, misalign, instret
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : pc_sequencer
// Brief    : Architectural PC with next-PC selection, alignment fault, trap
//            redirect and retired-instruction counter.
//            Optional macro C_EXT_EN: 16-bit instructions, 2-byte alignment.
// Revision : 1.0
// =============================================================================
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_sequencer_if.slave        bus
);
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [3:0] T_BRANCH = 4'd6;
    localparam logic [3:0] T_JALR   = 4'd7;
    localparam logic [3:0] T_JAL    = 4'd8;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  ilen;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  jump_pc;
    logic [XLEN-1:0]  jalr_pc;
    logic [XLEN-1:0]  tgt;
    logic [XLEN-1:0]  trap_pc;
    logic [XLEN-1:0]  pc_d;
    logic             tgt_misaligned;
    logic             pc_load;
    logic             cnt_inc;
    logic             valid;
    logic             fault;
    logic             unused_bits;

`ifdef C_EXT_EN
    assign ilen           = bus.instr_c ? XLEN'(2) : XLEN'(4);
    assign tgt_misaligned = 1'b0;
    assign trap_pc        = {bus.trap_vec[XLEN-1:1], 1'b0};
    assign unused_bits    = ^{bus.cword[22:4], bus.trap_vec[0]};
`else
    assign ilen           = XLEN'(4);
    assign tgt_misaligned = tgt[1];
    assign trap_pc        = {bus.trap_vec[XLEN-1:2], 2'b00};
    assign unused_bits    = ^{bus.cword[22:4], bus.instr_c, bus.trap_vec[1:0]};
`endif

    // All sums wrap modulo 2^XLEN; carry-out is intentionally dropped.
    assign seq_pc  = pc_q + ilen;
    assign jump_pc = pc_q + bus.imm;
    assign jalr_pc = (bus.r + bus.imm) & ~XLEN'(1);

    always_comb begin
        tgt = seq_pc;
        case (bus.cword[3:0])
            T_JAL:    tgt = jump_pc;
            T_JALR:   tgt = jalr_pc;
            T_BRANCH: tgt = bus.br_taken ? jump_pc : seq_pc;
            default:  tgt = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_BOOT:  state_nx = ST_RUN;
            ST_RUN:   if (!bus.trap_req && bus.adv && tgt_misaligned) state_nx = ST_FAULT;
            ST_FAULT: if (bus.trap_req) state_nx = ST_RUN;
            default:  state_nx = ST_BOOT;
        endcase
    end

    // Trap has priority over retirement; a faulting target leaves pc untouched.
    always_comb begin
        valid   = 1'b0;
        fault   = 1'b0;
        pc_load = 1'b0;
        pc_d    = tgt;
        cnt_inc = 1'b0;
        case (state)
            ST_RUN: begin
                valid = 1'b1;
                if (bus.trap_req) begin
                    pc_load = 1'b1;
                    pc_d    = trap_pc;
                end else if (bus.adv && !tgt_misaligned) begin
                    pc_load = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            ST_FAULT: begin
                fault = 1'b1;
                if (bus.trap_req) begin
                    pc_load = 1'b1;
                    pc_d    = trap_pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
        end else begin
            if (pc_load) pc_q <= pc_d;
            if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_next  = tgt;
    assign bus.link     = seq_pc;
    assign bus.pc_valid = valid;
    assign bus.misalign = fault;
    assign bus.instret  = cnt_q;
endmodule
`default_nettype wire
